// File: rtl/snd_pkg.sv
// Shared types and address map for the sound-board bus controller.
// The decode helper is the single source of truth for the region layout.
package snd_pkg;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_ROM,
        REG_POKEY,
        REG_MBOX,
        REG_STAT
    } region_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } stall_t;

    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] RAM_MASK   = 16'hF800;
    localparam logic [15:0] MBOX_ADDR  = 16'h1000;
    localparam logic [15:0] STAT_ADDR  = 16'h1010;
    localparam logic [15:0] IACK_ADDR  = 16'h1020;
    localparam logic [15:0] POKEY_BASE = 16'h1800;
    localparam logic [15:0] POKEY_MASK = 16'hFFF0;
    localparam logic [15:0] ROM_BASE   = 16'h4000;

    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;
    localparam int STAT_IRQ_BIT  = 2;

    // IRQ ack lives outside the readable regions and is matched separately.
    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if ((addr & RAM_MASK) == RAM_BASE) begin
            r = REG_RAM;
        end else if (addr == MBOX_ADDR) begin
            r = REG_MBOX;
        end else if (addr == STAT_ADDR) begin
            r = REG_STAT;
        end else if ((addr & POKEY_MASK) == POKEY_BASE) begin
            r = REG_POKEY;
        end else if (addr >= ROM_BASE) begin
            r = REG_ROM;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/snd_bus_if.sv
// 6502 side of the sound bus: address, write strobe, data both ways and RDY.
interface snd_bus_if;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        rdy;

    modport master (
        output ab,
        output we,
        output cpu_do,
        input  cpu_di,
        input  rdy
    );

    modport slave (
        input  ab,
        input  we,
        input  cpu_do,
        output cpu_di,
        output rdy
    );
endinterface

// File: rtl/snd_bus_ctrl_irq_timer.sv
// Free-running periodic tick with a sticky IRQ flag; terminal count beats ack.
module snd_irq_timer #(
    parameter int unsigned IRQ_PERIOD = 61440
) (
    input  logic clk,
    input  logic reset,
    input  logic ack,
    output logic irq
);

    localparam logic [15:0] LAST_COUNT = 16'(IRQ_PERIOD - 32'd1);

    logic [15:0] cnt_r;
    logic        irq_r;
    logic        tc_s;

    assign tc_s = (cnt_r == LAST_COUNT);

    // Period counter and sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 16'd0;
            irq_r <= 1'b0;
        end else begin
            if (tc_s) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
            if (tc_s) begin
                irq_r <= 1'b1;
            end else if (ack) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign irq = irq_r;

endmodule

// File: rtl/snd_bus_ctrl.sv
// Sound-board 6502 bus controller: decode, read mux, ROM stall, IRQ timer,
// command mailbox (drives NMI) and one-byte reply path.
module snd_bus_ctrl
    import snd_pkg::*;
#(
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned IRQ_PERIOD = 61440
) (
    input  logic        clk,
    input  logic        reset,
    snd_bus_if.slave    bus,
    output logic        ram_cs,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic        rom_cs,
    input  logic [7:0]  rom_rdata,
    output logic        pokey_cs,
    output logic        pokey_we,
    input  logic [7:0]  pokey_rdata,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_data,
    output logic [7:0]  reply_data,
    output logic        reply_valid,
    output logic        sndnmi,
    output logic        sndirq
);

    localparam bit       HAS_WAIT  = (ROM_WAIT != 32'd0);
    localparam logic [2:0] WAIT_LOAD = 3'((ROM_WAIT > 32'd0) ? (ROM_WAIT - 32'd1) : 32'd0);

    region_t     region_s;
    region_t     rd_region_r;
    stall_t      state_r;
    logic [2:0]  wait_cnt_r;
    logic        rom_rd_s;
    logic        rdy_s;
    logic        accept_s;
    logic        mbox_rd_s;
    logic        mbox_wr_s;
    logic        stat_rd_s;
    logic        iack_s;
    logic        ram_cs_s;
    logic        ram_we_s;
    logic        rom_cs_s;
    logic        pokey_cs_s;
    logic        pokey_we_s;
    logic [7:0]  cpu_di_s;
    logic [7:0]  status_s;
    logic [7:0]  cmd_latch_r;
    logic        cmd_full_r;
    logic        overrun_r;
    logic [7:0]  mbox_q_r;
    logic [7:0]  stat_q_r;
    logic [7:0]  reply_data_r;
    logic        reply_valid_r;
    logic        irq_s;

    assign region_s = decode_region(bus.ab);
    assign rom_rd_s = (region_s == REG_ROM) & ~bus.we;

    // Chip selects, forced inactive while in reset
    always_comb begin
        ram_cs_s   = 1'b0;
        ram_we_s   = 1'b0;
        rom_cs_s   = 1'b0;
        pokey_cs_s = 1'b0;
        pokey_we_s = 1'b0;
        if (reset) begin
            ram_cs_s   = 1'b0;
            rom_cs_s   = 1'b0;
            pokey_cs_s = 1'b0;
        end else begin
            ram_cs_s   = (region_s == REG_RAM);
            ram_we_s   = (region_s == REG_RAM) & bus.we;
            rom_cs_s   = rom_rd_s;
            pokey_cs_s = (region_s == REG_POKEY);
            pokey_we_s = (region_s == REG_POKEY) & bus.we;
        end
    end

    // RDY: the first cycle of a slow ROM read stalls before the FSM has moved
    always_comb begin
        rdy_s = 1'b1;
        if (reset) begin
            rdy_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (HAS_WAIT && rom_rd_s) begin
                        rdy_s = 1'b0;
                    end else begin
                        rdy_s = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r != 3'd0) begin
                        rdy_s = 1'b0;
                    end else begin
                        rdy_s = 1'b1;
                    end
                end
                default: rdy_s = 1'b1;
            endcase
        end
    end

    assign accept_s  = rdy_s & ~reset;
    assign mbox_rd_s = accept_s & ~bus.we & (region_s == REG_MBOX);
    assign mbox_wr_s = accept_s &  bus.we & (region_s == REG_MBOX);
    assign stat_rd_s = accept_s & ~bus.we & (region_s == REG_STAT);
    assign iack_s    = accept_s &  bus.we & (bus.ab == IACK_ADDR);

    // ROM stall FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (HAS_WAIT && rom_rd_s) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= WAIT_LOAD;
                    end else begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r != 3'd0) begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Status snapshot assembled from the live flags
    always_comb begin
        status_s                = 8'h00;
        status_s[STAT_FULL_BIT] = cmd_full_r;
        status_s[STAT_OVR_BIT]  = overrun_r;
        status_s[STAT_IRQ_BIT]  = irq_s;
    end

    // Region and register snapshots captured when the CPU cycle is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_region_r <= REG_NONE;
            mbox_q_r    <= 8'h00;
            stat_q_r    <= 8'h00;
        end else if (accept_s) begin
            rd_region_r <= region_s;
            mbox_q_r    <= cmd_latch_r;
            stat_q_r    <= status_s;
        end else begin
            rd_region_r <= rd_region_r;
            mbox_q_r    <= mbox_q_r;
            stat_q_r    <= stat_q_r;
        end
    end

    // Read data mux, one cycle behind the address
    always_comb begin
        case (rd_region_r)
            REG_RAM:   cpu_di_s = ram_rdata;
            REG_ROM:   cpu_di_s = rom_rdata;
            REG_POKEY: cpu_di_s = pokey_rdata;
            REG_MBOX:  cpu_di_s = mbox_q_r;
            REG_STAT:  cpu_di_s = stat_q_r;
            default:   cpu_di_s = 8'hFF;
        endcase
    end

    // Command mailbox; a new command always wins over a same-cycle read/clear
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_latch_r <= 8'h00;
            cmd_full_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (cmd_wr) begin
                cmd_latch_r <= cmd_data;
            end else begin
                cmd_latch_r <= cmd_latch_r;
            end
            if (cmd_wr) begin
                cmd_full_r <= 1'b1;
            end else if (mbox_rd_s) begin
                cmd_full_r <= 1'b0;
            end else begin
                cmd_full_r <= cmd_full_r;
            end
            if (cmd_wr && cmd_full_r) begin
                overrun_r <= 1'b1;
            end else if (stat_rd_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Reply byte and its one-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            reply_data_r  <= 8'h00;
            reply_valid_r <= 1'b0;
        end else begin
            reply_valid_r <= mbox_wr_s;
            if (mbox_wr_s) begin
                reply_data_r <= bus.cpu_do;
            end else begin
                reply_data_r <= reply_data_r;
            end
        end
    end

    snd_irq_timer #(
        .IRQ_PERIOD (IRQ_PERIOD)
    ) u_irq_timer (
        .clk   (clk),
        .reset (reset),
        .ack   (iack_s),
        .irq   (irq_s)
    );

    assign bus.cpu_di  = cpu_di_s;
    assign bus.rdy     = rdy_s;
    assign ram_cs      = ram_cs_s;
    assign ram_we      = ram_we_s;
    assign rom_cs      = rom_cs_s;
    assign pokey_cs    = pokey_cs_s;
    assign pokey_we    = pokey_we_s;
    assign reply_data  = reply_data_r;
    assign reply_valid = reply_valid_r;
    assign sndnmi      = cmd_full_r;
    assign sndirq      = irq_s;

endmodule

// File: tb/tb_snd_bus_ctrl.sv
// Directed bench for snd_bus_ctrl: a per-cycle behavioural model plus literal checks.
// A second instance with a longer ROM wait covers reset during a stall.
module tb_snd_bus_ctrl;

    localparam int ROM_WAIT  = 2;
    localparam int ROM_WAIT3 = 3;
    localparam int P         = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ram_rdata;
    logic [7:0]  rom_rdata;
    logic [7:0]  pokey_rdata;
    logic        cmd_wr;
    logic [7:0]  cmd_data;
    logic        ram_cs, ram_we, rom_cs, pokey_cs, pokey_we;
    logic [7:0]  reply_data;
    logic        reply_valid, sndnmi, sndirq;
    logic        ram_cs3, ram_we3, rom_cs3, pokey_cs3, pokey_we3;
    logic [7:0]  reply_data3;
    logic        reply_valid3, sndnmi3, sndirq3;
    logic [7:0]  mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    snd_bus_if bus ();
    snd_bus_if bus3 ();

    always #5 clk = ~clk;

    snd_bus_ctrl #(.ROM_WAIT(ROM_WAIT), .IRQ_PERIOD(P)) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .rom_cs(rom_cs), .rom_rdata(rom_rdata),
        .pokey_cs(pokey_cs), .pokey_we(pokey_we), .pokey_rdata(pokey_rdata),
        .cmd_wr(cmd_wr), .cmd_data(cmd_data),
        .reply_data(reply_data), .reply_valid(reply_valid),
        .sndnmi(sndnmi), .sndirq(sndirq)
    );

    snd_bus_ctrl #(.ROM_WAIT(ROM_WAIT3), .IRQ_PERIOD(P)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_rdata(ram_rdata),
        .rom_cs(rom_cs3), .rom_rdata(rom_rdata),
        .pokey_cs(pokey_cs3), .pokey_we(pokey_we3), .pokey_rdata(pokey_rdata),
        .cmd_wr(cmd_wr), .cmd_data(cmd_data),
        .reply_data(reply_data3), .reply_valid(reply_valid3),
        .sndnmi(sndnmi3), .sndirq(sndirq3)
    );

    // Block RAM behind the main instance, one-cycle read latency
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[bus.ab[10:0]] <= bus.cpu_do;
        ram_rdata <= mem[bus.ab[10:0]];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cmd_wr = 1'b0;
    endtask

    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        bus.ab  = a;  bus.we  = w;  bus.cpu_do  = d;
        bus3.ab = a;  bus3.we = w;  bus3.cpu_do = d;
    endtask

    // Behavioural model of the main instance, evaluated mid-cycle
    initial begin : ref_model
        int         t, rom_age, di_kind;
        bit         di_valid, m_irq, m_full, m_ovr, m_rv, n_ovr, n_full;
        bit         r_ram, r_rom, r_pok, r_mbox, r_stat, r_ack, e_rdy, rd, wr, tc;
        logic [7:0] m_latch, m_rd, m_const, e_di;
        logic [15:0] a;
        logic       w;
        t = 0; rom_age = 0; di_kind = 0; di_valid = 1'b0;
        m_irq = 1'b0; m_full = 1'b0; m_ovr = 1'b0; m_rv = 1'b0;
        m_latch = 8'h00; m_rd = 8'h00; m_const = 8'hFF;
        forever begin
            @(negedge clk);
            if (reset) begin
                t = 0; rom_age = 0; di_valid = 1'b0;
                m_irq = 1'b0; m_full = 1'b0; m_ovr = 1'b0; m_rv = 1'b0;
                m_latch = 8'h00; m_rd = 8'h00;
            end else begin
                a = bus.ab; w = bus.we;
                r_ram  = (a < 16'h0800);
                r_mbox = (a == 16'h1000);
                r_stat = (a == 16'h1010);
                r_ack  = (a == 16'h1020);
                r_pok  = (a >= 16'h1800) && (a <= 16'h180F);
                r_rom  = (a >= 16'h4000);
                e_rdy  = !(r_rom && !w) || (rom_age == ROM_WAIT);
                chk("m_rdy", {15'd0, bus.rdy}, {15'd0, e_rdy});
                chk("m_ram_cs", {15'd0, ram_cs}, {15'd0, r_ram});
                chk("m_ram_we", {15'd0, ram_we}, {15'd0, r_ram && w});
                chk("m_rom_cs", {15'd0, rom_cs}, {15'd0, r_rom && !w});
                chk("m_pokey_cs", {15'd0, pokey_cs}, {15'd0, r_pok});
                chk("m_pokey_we", {15'd0, pokey_we}, {15'd0, r_pok && w});
                chk("m_sndnmi", {15'd0, sndnmi}, {15'd0, m_full});
                chk("m_sndirq", {15'd0, sndirq}, {15'd0, m_irq});
                chk("m_reply_valid", {15'd0, reply_valid}, {15'd0, m_rv});
                chk("m_reply_data", {8'd0, reply_data}, {8'd0, m_rd});
                if (di_valid) begin
                    case (di_kind)
                        1:       e_di = ram_rdata;
                        2:       e_di = rom_rdata;
                        3:       e_di = pokey_rdata;
                        4:       e_di = m_const;
                        default: e_di = 8'hFF;
                    endcase
                    chk("m_cpu_di", {8'd0, bus.cpu_di}, {8'd0, e_di});
                end
                rd = e_rdy && !w;
                wr = e_rdy && w;
                if (r_rom && !w && !e_rdy) rom_age++; else rom_age = 0;
                di_valid = rd;
                if (rd) begin
                    di_kind = r_ram ? 1 : r_rom ? 2 : r_pok ? 3 : (r_mbox || r_stat) ? 4 : 0;
                    m_const = r_mbox ? m_latch : {5'b0, m_irq, m_ovr, m_full};
                end
                n_ovr  = (cmd_wr && m_full) ? 1'b1 : (rd && r_stat) ? 1'b0 : m_ovr;
                n_full = cmd_wr ? 1'b1 : (rd && r_mbox) ? 1'b0 : m_full;
                m_ovr = n_ovr; m_full = n_full;
                if (cmd_wr) m_latch = cmd_data;
                m_rv = wr && r_mbox;
                if (m_rv) m_rd = bus.cpu_do;
                tc = ((t % P) == (P - 1));
                m_irq = tc ? 1'b1 : (wr && r_ack) ? 1'b0 : m_irq;
                t++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        reset = 1'b1; cmd_wr = 1'b0; cmd_data = 8'h00;
        rom_rdata = 8'hA9; pokey_rdata = 8'h3C;
        drive(16'h0000, 1'b0, 8'h00);
        repeat (3) nxt();
        #2;
        chk("sel_in_reset", {13'd0, ram_cs, rom_cs, pokey_cs}, 16'h0000);
        chk("rdy_in_reset", {15'd0, bus.rdy}, 16'h0001);

        // cycle 0: reset values
        nxt(); reset = 1'b0; drive(16'h2000, 1'b0, 8'h00); #2;
        chk("rst_rdy", {15'd0, bus.rdy}, 16'h0001);
        chk("rst_cpu_di", {8'd0, bus.cpu_di}, 16'h00FF);
        chk("rst_sndnmi", {15'd0, sndnmi}, 16'h0000);
        chk("rst_sndirq", {15'd0, sndirq}, 16'h0000);
        chk("rst_reply_valid", {15'd0, reply_valid}, 16'h0000);
        chk("rst_reply_data", {8'd0, reply_data}, 16'h0000);

        // IRQ timer: rises on cycle 16, ack clears, ack on terminal count loses
        repeat (15) nxt(); #2;
        chk("irq_c15", {15'd0, sndirq}, 16'h0000);
        nxt(); #2;
        chk("irq_c16", {15'd0, sndirq}, 16'h0001);
        nxt(); drive(16'h1020, 1'b1, 8'h00); #2;
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("irq_ack_clr", {15'd0, sndirq}, 16'h0000);
        repeat (13) nxt();
        drive(16'h1020, 1'b1, 8'h00); #2;
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("irq_set_wins", {15'd0, sndirq}, 16'h0001);

        // Reset during a ROM stall on both instances
        nxt(); cmd_wr = 1'b1; cmd_data = 8'h11; #2;
        nxt(); #2;
        chk("pre_rst_nmi3", {15'd0, sndnmi3}, 16'h0001);
        chk("pre_rst_irq3", {15'd0, sndirq3}, 16'h0001);
        nxt(); drive(16'h8000, 1'b0, 8'h00); #2;
        chk("stall_start", {14'd0, bus.rdy, bus3.rdy}, 16'h0000);
        nxt(); reset = 1'b1; #2;
        nxt(); reset = 1'b0; drive(16'h2000, 1'b0, 8'h00); #2;
        chk("wrst_rdy3", {15'd0, bus3.rdy}, 16'h0001);
        chk("wrst_rdy", {15'd0, bus.rdy}, 16'h0001);
        chk("wrst_nmi3", {15'd0, sndnmi3}, 16'h0000);
        chk("wrst_irq3", {15'd0, sndirq3}, 16'h0000);
        chk("wrst_di3", {8'd0, bus3.cpu_di}, 16'h00FF);
        chk("wrst_di", {8'd0, bus.cpu_di}, 16'h00FF);

        // RAM write then read
        nxt(); drive(16'h0123, 1'b1, 8'h5A); #2;
        chk("ram_wr_sel", {14'd0, ram_cs, ram_we}, 16'h0003);
        nxt(); drive(16'h0123, 1'b0, 8'h00); #2;
        chk("ram_rd_we", {14'd0, ram_cs, ram_we}, 16'h0002);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("ram_rd_data", {8'd0, bus.cpu_di}, 16'h005A);

        // POKEY write and read
        nxt(); drive(16'h1802, 1'b1, 8'h77); #2;
        chk("pokey_wr_sel", {14'd0, pokey_cs, pokey_we}, 16'h0003);
        nxt(); drive(16'h1805, 1'b0, 8'h00); #2;
        chk("pokey_rd_sel", {14'd0, pokey_cs, pokey_we}, 16'h0002);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("pokey_rd_data", {8'd0, bus.cpu_di}, 16'h003C);

        // ROM read with two stall cycles
        nxt(); drive(16'h8000, 1'b0, 8'h00); #2;
        chk("rom_stall0", {14'd0, bus.rdy, rom_cs}, 16'h0001);
        nxt(); #2;
        chk("rom_stall1", {15'd0, bus.rdy}, 16'h0000);
        nxt(); #2;
        chk("rom_release", {15'd0, bus.rdy}, 16'h0001);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("rom_data", {8'd0, bus.cpu_di}, 16'h00A9);
        nxt(); #2;
        chk("unmapped_rd", {8'd0, bus.cpu_di}, 16'h00FF);

        // ROM write is dropped without a select or stall
        nxt(); drive(16'hC000, 1'b1, 8'h12); #2;
        chk("rom_wr_nosel", {13'd0, ram_cs, rom_cs, pokey_cs}, 16'h0000);
        chk("rom_wr_rdy", {15'd0, bus.rdy}, 16'h0001);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("rom_wr_after", {15'd0, bus.rdy}, 16'h0001);

        // Mailbox command, read, overrun and status
        nxt(); cmd_wr = 1'b1; cmd_data = 8'h33; #2;
        nxt(); #2;
        chk("cmd_nmi_set", {15'd0, sndnmi}, 16'h0001);
        nxt(); drive(16'h1000, 1'b0, 8'h00); #2;
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("cmd_rd_data", {8'd0, bus.cpu_di}, 16'h0033);
        chk("cmd_nmi_clr", {15'd0, sndnmi}, 16'h0000);
        nxt(); cmd_wr = 1'b1; cmd_data = 8'h44; #2;
        nxt(); cmd_wr = 1'b1; cmd_data = 8'h55; #2;
        nxt(); drive(16'h1010, 1'b0, 8'h00); #2;
        nxt(); #2;
        chk("stat_full_ovr", {8'd0, bus.cpu_di & 8'h03}, 16'h0003);
        chk("stat_hi_zero", {8'd0, bus.cpu_di & 8'hF8}, 16'h0000);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("stat_ovr_clr", {8'd0, bus.cpu_di & 8'h03}, 16'h0001);

        // Command arriving on the same cycle as the mailbox read
        nxt(); drive(16'h1000, 1'b0, 8'h00); cmd_wr = 1'b1; cmd_data = 8'h66; #2;
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("coinc_old_byte", {8'd0, bus.cpu_di}, 16'h0055);
        chk("coinc_nmi_kept", {15'd0, sndnmi}, 16'h0001);
        nxt(); drive(16'h1000, 1'b0, 8'h00); #2;
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("coinc_new_byte", {8'd0, bus.cpu_di}, 16'h0066);
        chk("coinc_nmi_clr", {15'd0, sndnmi}, 16'h0000);

        // Reply path
        nxt(); drive(16'h1000, 1'b1, 8'h7E); #2;
        chk("reply_pre", {15'd0, reply_valid}, 16'h0000);
        nxt(); drive(16'h2000, 1'b0, 8'h00); #2;
        chk("reply_pulse", {15'd0, reply_valid}, 16'h0001);
        chk("reply_data", {8'd0, reply_data}, 16'h007E);
        nxt(); #2;
        chk("reply_once", {15'd0, reply_valid}, 16'h0000);
        chk("reply_hold", {8'd0, reply_data}, 16'h007E);

        repeat (4) nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
